tlb: RTL and testbench
======================

TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8, giving the number of fully-associative entries (power of two, 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port clear_tlb, input, 1 bit: invalidates all entries.
REQ-005 SHALL have port req_valid, input, 1 bit: translation request.
REQ-006 SHALL have port req_va, input, 64 bits: request virtual address.
REQ-007 SHALL have port req_store, input, 1 bit: request is a store.
REQ-008 SHALL have port req_ready, output, 1 bit: TLB can accept a request.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-010 SHALL have port rsp_pa, output, 64 bits: translated physical address.
REQ-011 SHALL have port rsp_fault, output, 1 bit: translation or permission fault.
REQ-012 SHALL have port walk_req, output, 1 bit: one-cycle request pulse to the page walker.
REQ-013 SHALL have port walk_va, output, 64 bits: virtual address sent to the walker.
REQ-014 SHALL have port walk_gnt, input, 1 bit: the walker accepted the request.
REQ-015 SHALL have port walk_rsp_valid, input, 1 bit: walker result valid.
REQ-016 SHALL have port walk_rsp, input, page_walk_rsp_t: walker result (paddr, fault, dirty, readable, writable, executable, user, pgsize).
REQ-017 SHALL have port mark_dirty_valid, output, 1 bit: one-cycle dirty-mark request pulse.
REQ-018 SHALL have port mark_dirty_addr, output, 64 bits: virtual address to mark dirty.
REQ-019 SHALL have port mark_dirty_rsp_valid, input, 1 bit: dirty mark completed.

Function
REQ-020 SHALL implement the states IDLE, WALK_REQ, WALK_WAIT, DIRTY_REQ, DIRTY_WAIT and RESP, and SHALL drive req_ready=1 only in IDLE.
REQ-021 SHALL perform the lookup combinationally in IDLE when req_valid=1, matching valid entries on va[38:30] (pgsize 0), va[38:21] (pgsize 1) or va[38:12] (pgsize 2).
REQ-022 SHALL produce the hit pa as the entry pa bits above the page offset concatenated with the va page offset.
REQ-023 SHALL, on a hit with no fault and no dirty work pending, assert rsp_valid in the next cycle (1-cycle latency).
REQ-024 SHALL detect a permission fault when a load hits a non-readable page or a store hits a non-writable page; the response is rsp_fault=1, rsp_pa=0 and the entry is kept.
REQ-025 SHALL, on a miss, latch the va and go to WALK_REQ, pulsing walk_req with walk_va held stable.
REQ-026 SHALL hold walk_va and re-pulse walk_req each cycle until walk_gnt=1, then enter WALK_WAIT.
REQ-027 SHALL, on walk_rsp_valid with fault=1, return rsp_fault=1 in RESP and not fill an entry.
REQ-028 SHALL otherwise fill an entry and apply REQ-023/024/029 as if the access had hit.
REQ-029 SHALL, for a store to a writable page with dirty=0, pulse mark_dirty_valid in DIRTY_REQ, wait in DIRTY_WAIT for mark_dirty_rsp_valid, set the entry dirty bit, then respond in RESP.
REQ-030 SHALL choose the fill victim as the lowest-index invalid entry, otherwise the round-robin pointer, which advances by 1 per fill and wraps from N_ENTRIES-1 to 0.
REQ-031 SHALL, on clear_tlb, clear all valid bits in the next cycle.
REQ-032 SHALL, when clear_tlb arrives during WALK_REQ/WALK_WAIT, still return the walk result but suppress the fill.
REQ-033 SHALL give a fill in the same cycle as clear_tlb lower priority than the clear (no fill occurs).
REQ-034 SHALL ignore walk_rsp_valid and mark_dirty_rsp_valid outside their wait states.

Reset
REQ-035 SHALL, on reset assertion, asynchronously force state IDLE, all valid bits 0, round-robin pointer 0, and rsp_valid, rsp_fault, walk_req and mark_dirty_valid to 0.
REQ-036 SHALL, on reset assertion, set rsp_pa, walk_va and mark_dirty_addr to 0.
REQ-037 SHALL abandon an in-flight walk when reset asserts mid-operation, with no response issued after reset release.

Configuration
REQ-038 SHALL, with TLB_STATS_EN defined, add 64-bit output ports hit_count and miss_count, which reset to 0 and increment once per accepted request.
REQ-039 SHALL, without TLB_STATS_EN, omit those ports and counters entirely.

Structure
REQ-040 SHALL reuse page_walk_rsp_t from the existing shared header, and SHALL place the tlb_entry_t typedef and the tlb state enum in shared package tlb_pkg.
REQ-041 SHALL implement the match and pa merge in one combinational sub-module tlb_cam.

Verification
REQ-042 SHALL verify: a load at va 0x1000 misses, the walker returns pa 0x80002000 (pgsize 2, R=1, dirty=1), and rsp_pa=0x80002000; a reload of va 0x1008 then hits with 1-cycle latency and rsp_pa=0x80002008.
REQ-043 SHALL verify: a store to va 0x5000 on a page with W=1 and dirty=0 produces exactly one mark_dirty_valid with addr 0x5000, then rsp_valid after mark_dirty_rsp_valid; a second store produces no mark.
REQ-044 SHALL verify: a walk returning fault=1 gives rsp_fault=1 and no fill, and a retry of the same va walks again.
REQ-045 SHALL verify: a store hitting a page with W=0 gives rsp_fault=1 and no walk_req.
REQ-046 SHALL verify: filling N_ENTRIES+1 distinct pages evicts entry 0, so a lookup of the first va misses.
REQ-047 SHALL verify: clear_tlb asserted during WALK_WAIT still returns the response, and a following lookup of the same va misses.

Source files
------------

// File: rtl/page_walk_pkg.sv
// Shared page-walker interface types: the result record returned by the hardware page walker.
package page_walk_pkg;

  typedef struct packed {
    logic [63:0] paddr;
    logic        fault;
    logic        dirty;
    logic        readable;
    logic        writable;
    logic        executable;
    logic        user;
    logic [1:0]  pgsize;  // 0: 1 GiB, 1: 2 MiB, 2: 4 KiB
  } page_walk_rsp_t;

endpackage

// File: rtl/tlb_pkg.sv
// TLB shared types: entry record, controller state encoding and page-size aware helpers.
package tlb_pkg;

  typedef struct packed {
    logic         valid;
    logic [38:12] vpn;
    logic [63:12] ppn;
    logic [1:0]   pgsize;
    logic         dirty;
    logic         readable;
    logic         writable;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    StIdle, StWalkReq, StWalkWait, StDirtyReq, StDirtyWait, StResp
  } tlb_state_e;

  function automatic logic vpn_match(input logic [38:12] vpn, input logic [63:0] va,
                                     input logic [1:0] pgsize);
    case (pgsize)
      2'd0:    return vpn[38:30] == va[38:30];
      2'd1:    return vpn[38:21] == va[38:21];
      default: return vpn == va[38:12];
    endcase
  endfunction

  function automatic logic [63:0] pa_merge(input logic [63:12] ppn, input logic [63:0] va,
                                           input logic [1:0] pgsize);
    case (pgsize)
      2'd0:    return {ppn[63:30], va[29:0]};
      2'd1:    return {ppn[63:21], va[20:0]};
      default: return {ppn[63:12], va[11:0]};
    endcase
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// TLB match array: finds the lowest-index valid entry covering va and forms its physical address.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 8,
  parameter int unsigned IdxW      = $clog2(N_ENTRIES)
) (
  input  tlb_entry_t [N_ENTRIES-1:0] entries,
  input  logic [63:0]                va,
  output logic                       hit,
  output logic [IdxW-1:0]            hit_idx,
  output logic [63:0]                hit_pa
);

  logic unused_bits;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
      if (entries[i].valid && vpn_match(entries[i].vpn, va, entries[i].pgsize)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
    hit_pa = pa_merge(entries[hit_idx].ppn, va, entries[hit_idx].pgsize);
  end

  // Permission bits are consumed by the controller, not the matcher.
  always_comb begin
    unused_bits = ^va[63:39];
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      unused_bits = unused_bits ^ entries[i].dirty ^ entries[i].readable ^ entries[i].writable;
    end
  end

endmodule

// File: rtl/tlb.sv
// Fully-associative TLB with page-walk refill, permission checks and dirty-bit marking.
// Defining TLB_STATS_EN adds hit_count/miss_count output counters.
module tlb
  import page_walk_pkg::*, tlb_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_tlb,
  input  logic           req_valid,
  input  logic [63:0]    req_va,
  input  logic           req_store,
  output logic           req_ready,
  output logic           rsp_valid,
  output logic [63:0]    rsp_pa,
  output logic           rsp_fault,
  output logic           walk_req,
  output logic [63:0]    walk_va,
  input  logic           walk_gnt,
  input  logic           walk_rsp_valid,
  input  page_walk_rsp_t walk_rsp,
  output logic           mark_dirty_valid,
  output logic [63:0]    mark_dirty_addr,
  input  logic           mark_dirty_rsp_valid
`ifdef TLB_STATS_EN
  ,
  output logic [63:0]    hit_count,
  output logic [63:0]    miss_count
`endif
);

  localparam int unsigned IdxW = $clog2(N_ENTRIES);

  tlb_entry_t [N_ENTRIES-1:0] entries_q, entries_d;
  tlb_state_e                 state_q, state_d;
  logic [IdxW-1:0]            rr_q, rr_d, idx_q, idx_d, victim, cam_idx;
  logic [63:0]                va_q, va_d, pa_q, pa_d, rsp_pa_q, rsp_pa_d;
  logic [63:0]                walk_va_q, walk_va_d, mark_addr_q, mark_addr_d;
  logic                       store_q, store_d, clr_pend_q, clr_pend_d, rsp_fault_q, rsp_fault_d;
  logic                       cam_hit, resolve, fill;
  logic [63:0]                cam_pa, res_pa, res_va;
  logic                       from_walk, res_st, res_r, res_w, res_dirty, res_fault, res_mark;
  logic                       unused_bits;

  tlb_cam #(
    .N_ENTRIES(N_ENTRIES),
    .IdxW     (IdxW)
  ) u_cam (
    .entries(entries_q),
    .va     (req_va),
    .hit    (cam_hit),
    .hit_idx(cam_idx),
    .hit_pa (cam_pa)
  );

  // Hits and walk results share one permission/dirty decision path.
  assign from_walk = (state_q == StWalkWait);
  assign res_st    = from_walk ? store_q : req_store;
  assign res_va    = from_walk ? va_q : req_va;
  assign res_r     = from_walk ? walk_rsp.readable : entries_q[cam_idx].readable;
  assign res_w     = from_walk ? walk_rsp.writable : entries_q[cam_idx].writable;
  assign res_dirty = from_walk ? walk_rsp.dirty : entries_q[cam_idx].dirty;
  assign res_pa    = from_walk ? pa_merge(walk_rsp.paddr[63:12], va_q, walk_rsp.pgsize) : cam_pa;
  assign res_fault = res_st ? !res_w : !res_r;
  assign res_mark  = res_st && !res_dirty;

  always_comb begin
    victim = rr_q;
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) victim = IdxW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    entries_d   = entries_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    va_d        = va_q;
    pa_d        = pa_q;
    store_d     = store_q;
    rsp_pa_d    = rsp_pa_q;
    rsp_fault_d = rsp_fault_q;
    walk_va_d   = walk_va_q;
    mark_addr_d = mark_addr_q;
    clr_pend_d  = clr_pend_q;
    resolve     = 1'b0;
    fill        = 1'b0;

    unique case (state_q)
      StIdle: begin
        clr_pend_d = 1'b0;
        if (req_valid) begin
          va_d    = req_va;
          store_d = req_store;
          if (cam_hit) begin
            idx_d   = cam_idx;
            resolve = 1'b1;
          end else begin
            walk_va_d = req_va;
            state_d   = StWalkReq;
          end
        end
      end
      StWalkReq: begin
        if (walk_gnt) state_d = StWalkWait;
      end
      StWalkWait: begin
        if (walk_rsp_valid) begin
          if (walk_rsp.fault) begin
            state_d     = StResp;
            rsp_fault_d = 1'b1;
            rsp_pa_d    = '0;
          end else begin
            fill    = !clr_pend_q && !clear_tlb;
            idx_d   = victim;
            resolve = 1'b1;
          end
        end
      end
      StDirtyReq: state_d = StDirtyWait;
      StDirtyWait: begin
        if (mark_dirty_rsp_valid) begin
          entries_d[idx_q].dirty = 1'b1;
          state_d     = StResp;
          rsp_fault_d = 1'b0;
          rsp_pa_d    = pa_q;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (resolve) begin
      if (res_fault) begin
        state_d     = StResp;
        rsp_fault_d = 1'b1;
        rsp_pa_d    = '0;
      end else if (res_mark) begin
        state_d     = StDirtyReq;
        pa_d        = res_pa;
        mark_addr_d = res_va;
      end else begin
        state_d     = StResp;
        rsp_fault_d = 1'b0;
        rsp_pa_d    = res_pa;
      end
    end

    if (fill) begin
      entries_d[victim] = '{valid:    1'b1,
                            vpn:      va_q[38:12],
                            ppn:      walk_rsp.paddr[63:12],
                            pgsize:   walk_rsp.pgsize,
                            dirty:    walk_rsp.dirty,
                            readable: walk_rsp.readable,
                            writable: walk_rsp.writable};
      rr_d = rr_q + IdxW'(1);
    end

    if ((state_q == StWalkReq || state_q == StWalkWait) && clear_tlb) clr_pend_d = 1'b1;
    // Clear wins over a fill landing in the same cycle.
    if (clear_tlb) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) entries_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      entries_q   <= '0;
      rr_q        <= '0;
      idx_q       <= '0;
      va_q        <= '0;
      pa_q        <= '0;
      store_q     <= 1'b0;
      rsp_pa_q    <= '0;
      rsp_fault_q <= 1'b0;
      walk_va_q   <= '0;
      mark_addr_q <= '0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entries_q   <= entries_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      va_q        <= va_d;
      pa_q        <= pa_d;
      store_q     <= store_d;
      rsp_pa_q    <= rsp_pa_d;
      rsp_fault_q <= rsp_fault_d;
      walk_va_q   <= walk_va_d;
      mark_addr_q <= mark_addr_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  assign req_ready        = (state_q == StIdle);
  assign rsp_valid        = (state_q == StResp);
  assign rsp_fault        = rsp_fault_q;
  assign rsp_pa           = rsp_pa_q;
  assign walk_req         = (state_q == StWalkReq);
  assign walk_va          = walk_va_q;
  assign mark_dirty_valid = (state_q == StDirtyReq);
  assign mark_dirty_addr  = mark_addr_q;

  assign unused_bits = ^{walk_rsp.paddr[11:0], walk_rsp.executable, walk_rsp.user};

`ifdef TLB_STATS_EN
  logic [63:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StIdle && req_valid) begin
      if (cam_hit) hit_cnt_q <= hit_cnt_q + 64'd1;
      else         miss_cnt_q <= miss_cnt_q + 64'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: miss/hit, dirty marking, walk faults, permission faults,
// superpages, clear during walk, reset mid-walk and round-robin eviction.
module tb_tlb;
  import page_walk_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           clear_tlb = 1'b0, req_valid = 1'b0, req_store = 1'b0;
  logic [63:0]    req_va = '0;
  logic           req_ready, rsp_valid, rsp_fault, walk_req, mark_dirty_valid;
  logic [63:0]    rsp_pa, walk_va, mark_dirty_addr;
  logic           walk_gnt = 1'b0, walk_rsp_valid = 1'b0, mark_dirty_rsp_valid = 1'b0;
  page_walk_rsp_t walk_rsp = '0;
`ifdef TLB_STATS_EN
  logic [63:0]    hit_count, miss_count;
`endif

  int          vecs = 0, errs = 0;
  int          walks = 0, marks = 0, rsps = 0;
  logic [63:0] last_walk_va = '0, last_mark_addr = '0;
  int          lat, w0, m0, r0;
  logic [63:0] pa;
  logic        flt;

  tlb #(.N_ENTRIES(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .clear_tlb           (clear_tlb),
    .req_valid           (req_valid),
    .req_va              (req_va),
    .req_store           (req_store),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_pa              (rsp_pa),
    .rsp_fault           (rsp_fault),
    .walk_req            (walk_req),
    .walk_va             (walk_va),
    .walk_gnt            (walk_gnt),
    .walk_rsp_valid      (walk_rsp_valid),
    .walk_rsp            (walk_rsp),
    .mark_dirty_valid    (mark_dirty_valid),
    .mark_dirty_addr     (mark_dirty_addr),
    .mark_dirty_rsp_valid(mark_dirty_rsp_valid)
`ifdef TLB_STATS_EN
    ,
    .hit_count           (hit_count),
    .miss_count          (miss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (walk_req && walk_gnt) begin
      walks        <= walks + 1;
      last_walk_va <= walk_va;
    end
    if (mark_dirty_valid) begin
      marks          <= marks + 1;
      last_mark_addr <= mark_dirty_addr;
    end
    if (rsp_valid) rsps <= rsps + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic page_walk_rsp_t mk(input logic [63:0] paddr, input logic f, input logic d,
                                        input logic r, input logic w, input logic [1:0] ps);
    page_walk_rsp_t x;
    x          = '0;
    x.paddr    = paddr;
    x.fault    = f;
    x.dirty    = d;
    x.readable = r;
    x.writable = w;
    x.pgsize   = ps;
    return x;
  endfunction

  // One request; the walker grants on the second walk_req cycle, answers one cycle later
  // (optionally with clear_tlb in between) and dirty marks complete one cycle after the pulse.
  task automatic txn(input logic [63:0] va, input logic st, input page_walk_rsp_t wr,
                     input logic clr, output int lat_o, output logic [63:0] pa_o,
                     output logic flt_o);
    int   stage;
    logic held, mark_pend;
    stage = 0; held = 1'b0; mark_pend = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_va = va; req_store = st;
    @(negedge clk);
    req_valid = 1'b0;
    lat_o = 1;
    while (!rsp_valid && lat_o < 60) begin
      walk_gnt = 1'b0; walk_rsp_valid = 1'b0; mark_dirty_rsp_valid = 1'b0; clear_tlb = 1'b0;
      if (stage == 2) begin
        walk_rsp_valid = 1'b1; walk_rsp = wr; stage = 3;
      end else if (stage == 1) begin
        clear_tlb = clr; stage = 2;
      end
      if (walk_req) begin
        if (held) begin walk_gnt = 1'b1; stage = 1; end
        held = 1'b1;
      end
      if (mark_pend) begin mark_dirty_rsp_valid = 1'b1; mark_pend = 1'b0; end
      if (mark_dirty_valid) mark_pend = 1'b1;
      @(negedge clk);
      lat_o++;
    end
    walk_gnt = 1'b0; walk_rsp_valid = 1'b0; mark_dirty_rsp_valid = 1'b0; clear_tlb = 1'b0;
    check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
    pa_o  = rsp_pa;
    flt_o = rsp_fault;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_walk_req", {63'd0, walk_req}, 64'd0);
    check("rst_mark", {63'd0, mark_dirty_valid}, 64'd0);
    check("rst_rsp_pa", rsp_pa, 64'd0);
    check("rst_walk_va", walk_va, 64'd0);
    reset = 1'b1;

    // Miss, walk, fill; then a hit in the same 4 KiB page.
    w0 = walks;
    txn(64'h1000, 1'b0, mk(64'h8000_2000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("miss_walks", 64'(walks - w0), 64'd1);
    check("miss_walk_va", last_walk_va, 64'h1000);
    check("miss_pa", pa, 64'h8000_2000);
    check("miss_fault", {63'd0, flt}, 64'd0);
    w0 = walks;
    txn(64'h1008, 1'b0, mk(64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("hit_walks", 64'(walks - w0), 64'd0);
    check("hit_lat", 64'(lat), 64'd1);
    check("hit_pa", pa, 64'h8000_2008);

    // Store to a clean writable page marks dirty exactly once.
    m0 = marks;
    txn(64'h5000, 1'b1, mk(64'h9000_5000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2), 1'b0, lat, pa, flt);
    check("dirty_marks", 64'(marks - m0), 64'd1);
    check("dirty_addr", last_mark_addr, 64'h5000);
    check("dirty_pa", pa, 64'h9000_5000);
    check("dirty_fault", {63'd0, flt}, 64'd0);
    m0 = marks;
    txn(64'h5010, 1'b1, mk(64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("dirty2_marks", 64'(marks - m0), 64'd0);
    check("dirty2_lat", 64'(lat), 64'd1);
    check("dirty2_pa", pa, 64'h9000_5010);

    // Faulting walk does not fill; retry walks again.
    txn(64'h7000, 1'b0, mk(64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("wfault_fault", {63'd0, flt}, 64'd1);
    check("wfault_pa", pa, 64'd0);
    w0 = walks;
    txn(64'h7000, 1'b0, mk(64'hA000_7000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("retry_walks", 64'(walks - w0), 64'd1);
    check("retry_pa", pa, 64'hA000_7000);

    // Store hitting a read-only page faults without walking.
    w0 = walks; m0 = marks;
    txn(64'h7000, 1'b1, mk(64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("wperm_fault", {63'd0, flt}, 64'd1);
    check("wperm_pa", pa, 64'd0);
    check("wperm_walks", 64'(walks - w0), 64'd0);
    check("wperm_marks", 64'(marks - m0), 64'd0);
    check("wperm_lat", 64'(lat), 64'd1);

    // 2 MiB page: offset is va[20:0].
    txn(64'h4020_1234, 1'b0, mk(64'hC000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1), 1'b0, lat, pa, flt);
    check("mega_miss_pa", pa, 64'hC000_1234);
    w0 = walks;
    txn(64'h403F_FFF0, 1'b0, mk(64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1), 1'b0, lat, pa, flt);
    check("mega_hit_walks", 64'(walks - w0), 64'd0);
    check("mega_hit_pa", pa, 64'hC01F_FFF0);

    // clear_tlb during WALK_WAIT: response still returned, no fill, old entries gone.
    txn(64'h9000, 1'b0, mk(64'hB000_9000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 1'b1, lat, pa, flt);
    check("clr_pa", pa, 64'hB000_9000);
    check("clr_fault", {63'd0, flt}, 64'd0);
    w0 = walks;
    txn(64'h9000, 1'b0, mk(64'hB000_9000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("clr_rewalk", 64'(walks - w0), 64'd1);
    w0 = walks;
    txn(64'h1008, 1'b0, mk(64'h8000_2000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("clr_old_miss", 64'(walks - w0), 64'd1);

    // Reset mid-walk abandons the request.
    @(negedge clk);
    req_valid = 1'b1; req_va = 64'hD000; req_store = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_walk_req", {63'd0, walk_req}, 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_async_walk_req", {63'd0, walk_req}, 64'd0);
    check("midrst_walk_va", walk_va, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    r0 = rsps;
    walk_rsp_valid = 1'b1;
    walk_rsp = mk(64'hE000_D000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
    @(negedge clk);
    walk_rsp_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_rsp", 64'(rsps - r0), 64'd0);
    check("midrst_ready", {63'd0, req_ready}, 64'd1);

    // Nine distinct fills from empty: the ninth evicts entry 0.
    for (int i = 0; i < 9; i++) begin
      w0 = walks;
      txn(64'h10000 + 64'(i) * 64'h1000, 1'b0,
          mk(64'h2000_0000 + 64'(i) * 64'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 1'b0, lat, pa, flt);
      check("evict_fill_walk", 64'(walks - w0), 64'd1);
    end
    w0 = walks;
    txn(64'h18000, 1'b0, mk(64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("evict_new_hit", 64'(walks - w0), 64'd0);
    check("evict_new_pa", pa, 64'h2000_8000);
    w0 = walks;
    txn(64'h10000, 1'b0, mk(64'h2000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 1'b0, lat, pa, flt);
    check("evict_first_miss", 64'(walks - w0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
